// File: rtl/fp32_pkg.sv
// Shared FP32 constants, the multiplier FSM state type and a significand helper.
package fp32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_MANT_W  = 23;
    localparam int FP32_SIG_W   = 24;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    // 24-bit significand with hidden bit; denormals (exp==0) flush to zero.
    function automatic logic [FP32_SIG_W-1:0] fp32_sig(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? '0 : {1'b1, x[FP32_MANT_W-1:0]};
    endfunction

endpackage

// File: rtl/fp_mul_norm.sv
// Combinational normalise / truncate / range-pack of a 48-bit significand
// product into an FP32 word.
module fp_mul_norm
    import fp32_pkg::*;
(
    input  logic               i_sign,
    input  logic signed [9:0]  i_exp,
    input  logic [47:0]        i_prod,
    output logic [31:0]        o_result
);

    localparam logic signed [9:0] LP_EXP_MAX = FP32_EXP_MAX[9:0];

    logic signed [9:0]      w_exp_adj;
    logic [FP32_MANT_W-1:0] w_mant;

    // Leading one at bit 47 means the product is in [2,4): bump the exponent.
    always_comb begin
        if (i_prod[47]) begin
            w_exp_adj = i_exp + 10'sd1;
            w_mant    = i_prod[46:24];
        end else begin
            w_exp_adj = i_exp;
            w_mant    = i_prod[45:23];
        end
    end

    // Zero product or exponent underflow gives signed zero; overflow saturates to infinity.
    always_comb begin
        o_result = {i_sign, w_exp_adj[7:0], w_mant};
        if ((i_prod == '0) || (w_exp_adj <= 10'sd0)) begin
            o_result = {i_sign, 31'b0};
        end else if (w_exp_adj >= LP_EXP_MAX) begin
            o_result = {i_sign, 8'hFF, 23'b0};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative FP32 multiplier: shift-add significand product retiring
// BITS_PER_CYCLE multiplier bits per cycle, truncating rounding.
// Optional feature macro FP_MUL_ZERO_BYPASS_EN: zero operands skip MUL/NORM
// and go straight to DONE on the accept edge.
module fp_mul_seq
    import fp32_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int K = BITS_PER_CYCLE;
    localparam int N = FP32_SIG_W / K;
    localparam logic [4:0]        LP_CNT_LAST = 5'(N - 1);
    localparam logic signed [9:0] LP_BIAS     = FP32_BIAS[9:0];

    generate
        if (!(K == 1 || K == 2 || K == 3 || K == 4 || K == 6 || K == 8 || K == 12 || K == 24)) begin : g_bad_bpc
            $error("fp_mul_seq: BITS_PER_CYCLE must divide 24 (1,2,3,4,6,8,12,24)");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_ma;
    logic [23:0]       r_mb;
    logic [47:0]       r_acc;
    logic [4:0]        r_cnt;
    logic [31:0]       r_result;

    logic              w_accept;
    logic              w_bypass;
    logic              w_sign_in;
    logic [23:0]       w_sig_a;
    logic [23:0]       w_sig_b;
    logic signed [9:0] w_exp_sum;
    logic [23+K:0]     w_psum;
    logic [47+K:0]     w_cat;
    logic [47:0]       w_acc_next;
    logic [31:0]       w_norm_result;

    assign w_sig_a   = fp32_sig(a);
    assign w_sig_b   = fp32_sig(b);
    assign w_sign_in = a[31] ^ b[31];
    assign w_exp_sum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - LP_BIAS;
    assign w_accept  = in_valid && in_ready;

`ifdef FP_MUL_ZERO_BYPASS_EN
    assign w_bypass = (w_sig_a == '0) || (w_sig_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // One radix-2^K digit: add multiplicand*digit into the upper half, then shift
    // the whole accumulator right by K so the next digit lands at the same weight.
    assign w_psum     = {{K{1'b0}}, r_acc[47:24]} + ({{K{1'b0}}, r_ma} * {24'd0, r_mb[K-1:0]});
    assign w_cat      = {w_psum, r_acc[23:0]};
    assign w_acc_next = 48'(w_cat >> K);

    fp_mul_norm u_norm (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_prod   (r_acc),
        .o_result (w_norm_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = w_bypass ? DONE : MUL;
            end
            MUL:  if (r_cnt == LP_CNT_LAST) w_state_next = NORM;
            NORM: w_state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Iteration counter: restarts on every accept, wraps after the last digit.
    always_ff @(posedge clk) begin
        if (rst)                   r_cnt <= '0;
        else if (w_accept)         r_cnt <= '0;
        else if (r_state == MUL)   r_cnt <= (r_cnt == LP_CNT_LAST) ? 5'd0 : r_cnt + 5'd1;
    end

    // Operand capture on accept, shift-add iteration during MUL (data, no reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sign <= w_sign_in;
            r_exp  <= w_exp_sum;
            r_ma   <= w_sig_a;
            r_mb   <= w_sig_b;
            r_acc  <= '0;
        end else if (r_state == MUL) begin
            r_acc  <= w_acc_next;
            r_mb   <= r_mb >> K;
        end
    end

    // Result register: loads from the normaliser, or a signed zero on bypass.
    always_ff @(posedge clk) begin
        if (rst)                       r_result <= '0;
        else if (r_state == NORM)      r_result <= w_norm_result;
        else if (w_accept && w_bypass) r_result <= {w_sign_in, 31'b0};
    end

    assign result = r_result;

endmodule
